mux_key_table: RTL and testbench

- Programmable key→data lookup table with NR_KEY entries.
- Entries are written at run time, not fixed at elaboration.
- Lookups use a valid/ready request/response handshake with a registered, one-cycle result.
- Serves decode/select paths in the CPU where key mappings change (CSR/trap routing, remap tables) and a stall-tolerant lookup is needed.

---
 rtl/mux_key_table_if.sv | 28 ++
 rtl/mux_key_table.sv | 150 +++++++++++++++
 tb/tb_mux_key_table.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_key_table_if.sv
// Lookup request/response channel of the programmable key->data table.
// The requester uses the master modport, the table the slave modport.
interface mux_key_table_if #(
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8,
    parameter int IDX_W    = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic [DATA_LEN-1:0] default_out;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_LEN-1:0] resp_data;
    logic                resp_hit;
    logic                resp_multi;
    logic [IDX_W-1:0]    resp_idx;

    modport master (
        output req_valid, req_key, default_out, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_hit, resp_multi, resp_idx
    );

    modport slave (
        input  req_valid, req_key, default_out, resp_ready,
        output req_ready, resp_valid, resp_data, resp_hit, resp_multi, resp_idx
    );
endinterface

// File: rtl/mux_key_table.sv
// Run-time programmable key->data table with a registered, one-cycle
// valid/ready lookup port; table updates become visible one edge later.
module mux_key_table #(
    parameter  int NR_KEY      = 4,
    parameter  int KEY_LEN     = 4,
    parameter  int DATA_LEN    = 8,
    parameter  bit HAS_DEFAULT = 1'b0,
    parameter  bit PRIORITY    = 1'b1,
    localparam int IDX_W       = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [KEY_LEN-1:0]  wr_key_i,
    input  logic [DATA_LEN-1:0] wr_data_i,
    input  logic                inv_en_i,
    input  logic                clr_all_i,
    mux_key_table_if.slave      lkp
);

    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [KEY_LEN-1:0]  key_d  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] data_d [NR_KEY];
    logic [NR_KEY-1:0]   valid_q;
    logic [NR_KEY-1:0]   valid_d;

    logic                resp_valid_q, resp_valid_d;
    logic [DATA_LEN-1:0] resp_data_q,  resp_data_d;
    logic                resp_hit_q,   resp_hit_d;
    logic                resp_multi_q, resp_multi_d;
    logic [IDX_W-1:0]    resp_idx_q,   resp_idx_d;

    logic [NR_KEY-1:0]   match;
    logic                any_hit;
    logic                multi_hit;
    logic [IDX_W-1:0]    win_idx;
    logic [DATA_LEN-1:0] prio_data;
    logic [DATA_LEN-1:0] or_data;
    logic [DATA_LEN-1:0] lookup_data;
    logic                ready;
    logic                accept;

    // Match works on the registered table, so same-cycle writes only affect later lookups.
    always_comb begin
        match     = '0;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        win_idx   = '0;
        prio_data = '0;
        or_data   = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            match[i] = valid_q[i] && (key_q[i] == lkp.req_key);
            if (match[i]) begin
                if (any_hit) begin
                    multi_hit = 1'b1;
                end else begin
                    win_idx   = IDX_W'(i);
                    prio_data = data_q[i];
                end
                any_hit = 1'b1;
                or_data = or_data | data_q[i];
            end
        end
    end

    always_comb begin
        lookup_data = '0;
        if (any_hit) begin
            lookup_data = PRIORITY ? prio_data : or_data;
        end else if (HAS_DEFAULT) begin
            lookup_data = lkp.default_out;
        end
    end

    assign ready  = !resp_valid_q || lkp.resp_ready;
    assign accept = lkp.req_valid && ready;

    // clr_all beats wr_en beats inv_en; an out-of-range index matches no entry.
    always_comb begin
        key_d   = key_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_all_i) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_idx_i == IDX_W'(i)) begin
                    if (wr_en_i) begin
                        key_d[i]   = wr_key_i;
                        data_d[i]  = wr_data_i;
                        valid_d[i] = 1'b1;
                    end else if (inv_en_i) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_hit_d   = resp_hit_q;
        resp_multi_d = resp_multi_q;
        resp_idx_d   = resp_idx_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = lookup_data;
            resp_hit_d   = any_hit;
            resp_multi_d = multi_hit;
            resp_idx_d   = win_idx;
        end else if (lkp.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_multi_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            key_q        <= key_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_hit_q   <= resp_hit_d;
            resp_multi_q <= resp_multi_d;
            resp_idx_q   <= resp_idx_d;
        end
    end

    assign lkp.req_ready  = ready;
    assign lkp.resp_valid = resp_valid_q;
    assign lkp.resp_data  = resp_data_q;
    assign lkp.resp_hit   = resp_hit_q;
    assign lkp.resp_multi = resp_multi_q;
    assign lkp.resp_idx   = resp_idx_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Drives two tables (priority/no-default and OR/default) with one stimulus stream
// and compares both against a transaction-level model of the table and handshake.
module tb_mux_key_table;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 4;
    localparam int DATA_LEN = 8;
    localparam int IDX_W    = 2;

    typedef struct packed {
        logic                hit;
        logic                multi;
        logic [IDX_W-1:0]    idx;
        logic [DATA_LEN-1:0] data;
    } resp_t;

    logic                clk = 1'b0;
    logic                rstN;
    logic                wrEn;
    logic [IDX_W-1:0]    wrIdx;
    logic [KEY_LEN-1:0]  wrKey;
    logic [DATA_LEN-1:0] wrData;
    logic                invEn;
    logic                clrAll;
    logic                reqValid;
    logic [KEY_LEN-1:0]  reqKey;
    logic [DATA_LEN-1:0] defaultOut;
    logic                respReady;

    logic [KEY_LEN-1:0]  mKey   [NR_KEY];
    logic [DATA_LEN-1:0] mData  [NR_KEY];
    bit                  mValid [NR_KEY];
    resp_t               expA;
    resp_t               expB;
    bit                  expValid;
    int                  checks = 0;
    int                  errors = 0;

    always #5 clk = ~clk;

    mux_key_table_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) busA ();
    mux_key_table_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) busB ();

    assign busA.req_valid   = reqValid;
    assign busA.req_key     = reqKey;
    assign busA.default_out = defaultOut;
    assign busA.resp_ready  = respReady;
    assign busB.req_valid   = reqValid;
    assign busB.req_key     = reqKey;
    assign busB.default_out = defaultOut;
    assign busB.resp_ready  = respReady;

    mux_key_table #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
        .HAS_DEFAULT(1'b0), .PRIORITY(1'b1)
    ) dutA (
        .clk(clk), .rst_n(rstN), .wr_en_i(wrEn), .wr_idx_i(wrIdx), .wr_key_i(wrKey),
        .wr_data_i(wrData), .inv_en_i(invEn), .clr_all_i(clrAll), .lkp(busA.slave)
    );

    mux_key_table #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
        .HAS_DEFAULT(1'b1), .PRIORITY(1'b0)
    ) dutB (
        .clk(clk), .rst_n(rstN), .wr_en_i(wrEn), .wr_idx_i(wrIdx), .wr_key_i(wrKey),
        .wr_data_i(wrData), .inv_en_i(invEn), .clr_all_i(clrAll), .lkp(busB.slave)
    );

    // Reference lookup: count the matching valid entries and pick/merge their data.
    function automatic resp_t lookup(input logic [KEY_LEN-1:0] key, input logic [DATA_LEN-1:0] dflt,
                                     input bit prio, input bit hasDef);
        resp_t r;
        int    n;
        r = '0;
        n = 0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (mValid[i] && mKey[i] == key) begin
                if (n == 0) begin
                    r.idx = IDX_W'(i);
                    if (prio) r.data = mData[i];
                end
                if (!prio) r.data = r.data | mData[i];
                n++;
            end
        end
        r.hit   = (n > 0);
        r.multi = (n > 1);
        if (n == 0) r.data = hasDef ? dflt : '0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare both DUTs.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = reqValid && (!expValid || respReady);
        if (!rstN) begin
            for (int i = 0; i < NR_KEY; i++) begin
                mKey[i]   = '0;
                mData[i]  = '0;
                mValid[i] = 1'b0;
            end
            expValid = 1'b0;
            expA     = '0;
            expB     = '0;
        end else begin
            if (acc) begin
                expA     = lookup(reqKey, defaultOut, 1'b1, 1'b0);
                expB     = lookup(reqKey, defaultOut, 1'b0, 1'b1);
                expValid = 1'b1;
            end else if (respReady) begin
                expValid = 1'b0;
            end
            if (clrAll) begin
                for (int i = 0; i < NR_KEY; i++) mValid[i] = 1'b0;
            end else if (wrEn) begin
                mKey[wrIdx]   = wrKey;
                mData[wrIdx]  = wrData;
                mValid[wrIdx] = 1'b1;
            end else if (invEn) begin
                mValid[wrIdx] = 1'b0;
            end
        end
        #1;
        checkOutput("respValidA", 32'(busA.resp_valid), 32'(expValid));
        checkOutput("respValidB", 32'(busB.resp_valid), 32'(expValid));
        checkOutput("reqReadyA", 32'(busA.req_ready), 32'(!expValid || respReady));
        checkOutput("reqReadyB", 32'(busB.req_ready), 32'(!expValid || respReady));
        if (expValid) begin
            checkOutput("dataA", 32'(busA.resp_data), 32'(expA.data));
            checkOutput("hitA", 32'(busA.resp_hit), 32'(expA.hit));
            checkOutput("multiA", 32'(busA.resp_multi), 32'(expA.multi));
            checkOutput("idxA", 32'(busA.resp_idx), 32'(expA.idx));
            checkOutput("dataB", 32'(busB.resp_data), 32'(expB.data));
            checkOutput("hitB", 32'(busB.resp_hit), 32'(expB.hit));
            checkOutput("multiB", 32'(busB.resp_multi), 32'(expB.multi));
            checkOutput("idxB", 32'(busB.resp_idx), 32'(expB.idx));
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [IDX_W-1:0] idx, input logic [KEY_LEN-1:0] key,
                                 input logic [DATA_LEN-1:0] data, input bit inv, input bit clr,
                                 input bit rv, input logic [KEY_LEN-1:0] rk,
                                 input logic [DATA_LEN-1:0] dflt, input bit rr);
        wrEn       = we;
        wrIdx      = idx;
        wrKey      = key;
        wrData     = data;
        invEn      = inv;
        clrAll     = clr;
        reqValid   = rv;
        reqKey     = rk;
        defaultOut = dflt;
        respReady  = rr;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NR_KEY; i++) begin
            mKey[i] = '0; mData[i] = '0; mValid[i] = 1'b0;
        end
        expA = '0; expB = '0; expValid = 1'b0;
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstValid", 32'(busA.resp_valid), 32'd0);
        checkOutput("rstData", 32'(busA.resp_data), 32'd0);
        checkOutput("rstHit", 32'(busB.resp_hit), 32'd0);
        checkOutput("rstIdx", 32'(busB.resp_idx), 32'd0);
        rstN = 1'b1;

        // Empty table: key 0 must not match the zeroed, invalid entries.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 1);
        checkOutput("key0Miss", 32'(busA.resp_hit), 32'd0);

        applyStimulus(1, 0, 4'h3, 8'hA5, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 2, 4'h7, 8'h3C, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h7, 8'h00, 1);
        checkOutput("tp1Data", 32'(busA.resp_data), 32'h3C);
        checkOutput("tp1Idx", 32'(busA.resp_idx), 32'd2);
        checkOutput("tp1Multi", 32'(busA.resp_multi), 32'd0);

        applyStimulus(1, 1, 4'h5, 8'h0F, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 3, 4'h5, 8'hF0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h5, 8'h00, 1);
        checkOutput("dupDataA", 32'(busA.resp_data), 32'h0F);
        checkOutput("dupMultiA", 32'(busA.resp_multi), 32'd1);
        checkOutput("dupDataB", 32'(busB.resp_data), 32'hFF);
        checkOutput("dupIdxB", 32'(busB.resp_idx), 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h9, 8'h77, 1);
        checkOutput("missDataA", 32'(busA.resp_data), 32'h00);
        checkOutput("missDataB", 32'(busB.resp_data), 32'h77);
        checkOutput("missHitB", 32'(busB.resp_hit), 32'd0);

        // Backpressure: the held response must survive while a new request waits.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h7, 8'h00, 0);
            checkOutput("bpReady", 32'(busA.req_ready), 32'd0);
            checkOutput("bpData", 32'(busA.resp_data), 32'hA5);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h7, 8'h00, 1);
        checkOutput("noBubble", 32'(busA.resp_data), 32'h3C);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 1);
        checkOutput("burst0", 32'(busA.resp_data), 32'hA5);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h5, 8'h00, 1);
        checkOutput("burst1", 32'(busA.resp_data), 32'h0F);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h7, 8'h00, 1);
        checkOutput("burst2", 32'(busA.resp_data), 32'h3C);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h9, 8'h00, 1);
        checkOutput("burst3", 32'(busA.resp_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Same-cycle table update is invisible to the lookup accepted with it.
        applyStimulus(1, 0, 4'h3, 8'h11, 0, 0, 1, 4'h3, 8'h00, 1);
        checkOutput("sameWrOld", 32'(busA.resp_data), 32'hA5);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 1);
        checkOutput("sameWrNew", 32'(busA.resp_data), 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 4'h3, 8'h00, 1);
        checkOutput("clrOldHit", 32'(busA.resp_hit), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 1);
        checkOutput("clrMiss", 32'(busA.resp_hit), 32'd0);

        // Reset while a response is stalled drops it and empties the table.
        applyStimulus(1, 0, 4'h3, 8'h22, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 0);
        checkOutput("preRstData", 32'(busA.resp_data), 32'h22);
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 0);
        checkOutput("midRstValid", 32'(busA.resp_valid), 32'd0);
        checkOutput("midRstData", 32'(busA.resp_data), 32'd0);
        checkOutput("midRstHit", 32'(busA.resp_hit), 32'd0);
        checkOutput("midRstMulti", 32'(busB.resp_multi), 32'd0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h3, 8'h00, 1);
        checkOutput("postRst3", 32'(busA.resp_hit), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h7, 8'h00, 1);
        checkOutput("postRst7", 32'(busA.resp_hit), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h5, 8'h00, 1);
        checkOutput("postRst5", 32'(busB.resp_hit), 32'd0);

        // Random traffic over a small key space so duplicates and misses are common.
        for (int c = 0; c < 600; c++) begin
            rstN = ($urandom_range(0, 99) != 0);
            applyStimulus($urandom_range(0, 3) == 0, IDX_W'($urandom_range(0, NR_KEY - 1)),
                          KEY_LEN'($urandom_range(0, 7)), DATA_LEN'($urandom),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 9) < 7, KEY_LEN'($urandom_range(0, 7)),
                          DATA_LEN'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
